// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-sequencing controller for the program counter.
// Runs a program of PROG_VALUE+1 instructions with start/stall/branch/halt control.
// Optional build macro PC_SINGLE_STEP_EN: in RUN the PC only advances or branches
// on cycles where step=1. Without it, step is ignored.
module pc_sequencer #(
  parameter int unsigned PROG_VALUE = 3,
  parameter int unsigned WIDTH      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             halt,
  input  logic             step,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] LAST_PC = WIDTH'(PROG_VALUE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;
  logic   adv_c;
  logic   target_ok_c;

`ifdef PC_SINGLE_STEP_EN
  // Advance qualifier: only step pulses move the PC
  assign adv_c = step;
`else
  // Advance qualifier: every unstalled cycle moves the PC
  assign adv_c = 1'b1;
  logic unused_step;
  assign unused_step = step;
`endif

  // Branch target lies within the program
  assign target_ok_c = (branch_target <= LAST_PC);

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc_out   <= '0;
      pc_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state    <= RUN;
            pc_out   <= '0;
            pc_valid <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        RUN: begin
          if (halt) begin
            state    <= HALT;
            pc_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (stall) begin
            pc_out <= pc_out;
          end else if (branch_taken && !target_ok_c) begin
            state    <= HALT;
            pc_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b1;
          end else if (adv_c) begin
            if (branch_taken) begin
              pc_out <= branch_target;
            end else if (pc_out == LAST_PC) begin
              state    <= HALT;
              pc_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              pc_out <= pc_out + WIDTH'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          pc_out   <= '0;
          pc_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (PROG_VALUE=3, WIDTH=3).
// The driver pushes the expected post-edge outputs for every cycle it drives;
// a monitor pops and compares them just after each rising edge.
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stall;
  logic       branch_taken;
  logic [2:0] branch_target;
  logic       halt;
  logic       step;
  logic [2:0] pc_out;
  logic       pc_valid;
  logic       busy;
  logic       done;
  logic       err;

  typedef struct {
    string      tag;
    logic [2:0] pc;
    logic [3:0] flags; // {pc_valid, busy, done, err}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  pc_sequencer #(.PROG_VALUE(3), .WIDTH(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .step          (step),
    .pc_out        (pc_out),
    .pc_valid      (pc_valid),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic drive(input string tag, input logic r, input logic s, input logic st,
                       input logic br, input logic [2:0] tgt, input logic h, input logic sp,
                       input logic [2:0] epc, input logic [3:0] eflags);
    exp_t e;
    @(negedge clk);
    rst           = r;
    start         = s;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    halt          = h;
    step          = sp;
    e.tag   = tag;
    e.pc    = epc;
    e.flags = eflags;
    exp_q.push_back(e);
  endtask

  // Monitor: compare outputs against the scoreboard after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({pc_out, pc_valid, busy, done, err} !== {e.pc, e.flags}) begin
          n_fail++;
          $display("FAIL %s: got pc=%0d v/b/d/e=%b%b%b%b, expected pc=%0d v/b/d/e=%b",
                   e.tag, pc_out, pc_valid, busy, done, err, e.pc, e.flags);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 3'd0; halt = 1'b0; step = 1'b0;

    drive("reset0", 1, 0, 0, 0, 3'd0, 0, 0, 3'd0, 4'b0000);
    drive("reset1", 1, 0, 0, 0, 3'd0, 0, 0, 3'd0, 4'b0000);
`ifdef PC_SINGLE_STEP_EN
    drive("ss_start", 0, 1, 0, 0, 3'd0, 0, 0, 3'd0, 4'b1100);
    drive("ss_c1",    0, 0, 0, 0, 3'd0, 0, 0, 3'd0, 4'b1100);
    drive("ss_c2",    0, 0, 0, 0, 3'd0, 0, 1, 3'd1, 4'b1100);
    drive("ss_c3",    0, 0, 0, 0, 3'd0, 0, 0, 3'd1, 4'b1100);
    drive("ss_c4",    0, 0, 0, 0, 3'd0, 0, 0, 3'd1, 4'b1100);
    drive("ss_c5",    0, 0, 0, 0, 3'd0, 0, 1, 3'd2, 4'b1100);
    drive("ss_c6",    0, 0, 0, 0, 3'd0, 0, 0, 3'd2, 4'b1100);
    drive("ss_brhold",0, 0, 0, 1, 3'd0, 0, 0, 3'd2, 4'b1100);
    drive("ss_br",    0, 0, 0, 1, 3'd3, 0, 1, 3'd3, 4'b1100);
    drive("ss_last",  0, 0, 0, 0, 3'd0, 0, 0, 3'd3, 4'b1100);
    drive("ss_end",   0, 0, 0, 0, 3'd0, 0, 1, 3'd3, 4'b0010);
`else
    // Straight-line run to the end of the program
    drive("t1_start", 0, 1, 0, 0, 3'd0, 0, 0, 3'd0, 4'b1100);
    drive("t1_pc1",   0, 0, 0, 0, 3'd0, 0, 0, 3'd1, 4'b1100);
    drive("t1_pc2",   0, 0, 0, 0, 3'd0, 0, 0, 3'd2, 4'b1100);
    drive("t1_pc3",   0, 0, 0, 0, 3'd0, 0, 0, 3'd3, 4'b1100);
    drive("t1_halt",  0, 0, 0, 0, 3'd0, 0, 0, 3'd3, 4'b0010);
    drive("t1_hold",  0, 0, 1, 1, 3'd1, 1, 0, 3'd3, 4'b0010);
    // Stall at pc=1 for three cycles
    drive("t2_start", 0, 1, 0, 0, 3'd0, 0, 0, 3'd0, 4'b1100);
    drive("t2_pc1",   0, 0, 0, 0, 3'd0, 0, 0, 3'd1, 4'b1100);
    drive("t2_st1",   0, 0, 1, 0, 3'd0, 0, 0, 3'd1, 4'b1100);
    drive("t2_st2",   0, 0, 1, 0, 3'd0, 0, 0, 3'd1, 4'b1100);
    drive("t2_st3",   0, 0, 1, 1, 3'd3, 0, 0, 3'd1, 4'b1100);
    drive("t2_pc2",   0, 0, 0, 0, 3'd0, 0, 0, 3'd2, 4'b1100);
    drive("t2_pc3",   0, 0, 0, 0, 3'd0, 0, 0, 3'd3, 4'b1100);
    drive("t2_done",  0, 0, 0, 0, 3'd0, 0, 0, 3'd3, 4'b0010);
    // Branch to the last address, then out-of-range branch
    drive("t3_start", 0, 1, 0, 0, 3'd0, 0, 0, 3'd0, 4'b1100);
    drive("t3_br3",   0, 0, 0, 1, 3'd3, 0, 0, 3'd3, 4'b1100);
    drive("t3_done",  0, 0, 0, 0, 3'd0, 0, 0, 3'd3, 4'b0010);
    drive("t3_start2",0, 1, 0, 0, 3'd0, 0, 0, 3'd0, 4'b1100);
    drive("t3_br5",   0, 0, 0, 1, 3'd5, 0, 0, 3'd0, 4'b0011);
    drive("t3_sticky",0, 0, 0, 0, 3'd0, 0, 0, 3'd0, 4'b0011);
    drive("t3_clear", 0, 1, 0, 0, 3'd0, 0, 0, 3'd0, 4'b1100);
    // Start ignored in RUN; halt beats stall and a bad branch
    drive("t4_pc1",   0, 1, 0, 0, 3'd0, 0, 0, 3'd1, 4'b1100);
    drive("t4_pc2",   0, 0, 0, 0, 3'd0, 0, 0, 3'd2, 4'b1100);
    drive("t4_halt",  0, 0, 1, 1, 3'd7, 1, 0, 3'd2, 4'b0010);
    drive("t4_restart",0,1, 0, 0, 3'd0, 0, 0, 3'd0, 4'b1100);
    // Reset mid-run
    drive("t5_pc1",   0, 0, 0, 0, 3'd0, 0, 0, 3'd1, 4'b1100);
    drive("t5_pc2",   0, 0, 0, 0, 3'd0, 0, 0, 3'd2, 4'b1100);
    drive("t5_rst",   1, 0, 0, 1, 3'd1, 0, 0, 3'd0, 4'b0000);
    drive("t5_idle",  0, 0, 1, 1, 3'd2, 1, 0, 3'd0, 4'b0000);
`endif
    drive("final",    0, 0, 0, 0, 3'd0, 0, 0,
`ifdef PC_SINGLE_STEP_EN
          3'd3, 4'b0010);
`else
          3'd0, 4'b0000);
`endif

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
